// File: rtl/vga_sync_out_if.sv
// rtl/vga_sync_out_if.sv - raster position, colour and PMOD byte bundle for vga_sync_out
interface vga_sync_out_if;
  logic       ena;
  logic [5:0] rgb_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_cnt;
  logic [7:0] uo_out;

  // master: renderer/driver side; slave: the timing generator
  modport master (
    output ena, rgb_in,
    input  hpos, vpos, display_on, line_start, frame_start, frame_cnt, uo_out
  );

  modport slave (
    input  ena, rgb_in,
    output hpos, vpos, display_on, line_start, frame_start, frame_cnt, uo_out
  );
endinterface

// File: rtl/vga_sync_out.sv
// rtl/vga_sync_out.sv - VGA timing generator and registered TinyVGA PMOD output packer
module vga_sync_out #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_ACTIVE = 1'b0,
  parameter int PIPE        = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_out_if.slave  bus
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_IDLE = ~SYNC_ACTIVE;

  logic [9:0] hpos_q;
  logic [9:0] vpos_q;
  logic [7:0] frame_q;
  logic [7:0] uo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q  <= 10'd0;
      vpos_q  <= 10'd0;
      frame_q <= 8'd0;
    end else if (bus.ena) begin
      if (hpos_q == H_LAST) begin
        hpos_q <= 10'd0;
        if (vpos_q == V_LAST) begin
          vpos_q  <= 10'd0;
          frame_q <= frame_q + 8'd1;
        end else begin
          vpos_q <= vpos_q + 10'd1;
        end
      end else begin
        hpos_q <= hpos_q + 10'd1;
      end
    end
  end

  logic hsync_raw;
  logic vsync_raw;
  logic display_on;

  always_comb begin
    display_on = (hpos_q < H_VIS) && (vpos_q < V_VIS);
    hsync_raw  = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    vsync_raw  = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);
  end

  // {hsync asserted, vsync asserted, visible}; all-zero is blank with sync idle
  logic [2:0] raw;
  logic [2:0] aligned;
  assign raw = {hsync_raw, vsync_raw, display_on};

  generate
    if (PIPE == 0) begin : g_no_delay
      assign aligned = raw;
    end else begin : g_delay
      logic [2:0] stage [PIPE];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PIPE; i++) stage[i] <= 3'b000;
        end else if (bus.ena) begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE; i++) stage[i] <= stage[i-1];
        end
      end

      assign aligned = stage[PIPE-1];
    end
  endgenerate

  logic [5:0] colour;
  assign colour = aligned[0] ? bus.rgb_in : 6'd0;

  // PMOD byte {hsync,B0,G0,R0,vsync,B1,G1,R1} from colour {R1,R0,G1,G0,B1,B0}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uo_q <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
    end else if (bus.ena) begin
      uo_q <= {aligned[2] ? SYNC_ACTIVE : SYNC_IDLE, colour[0], colour[2], colour[4],
               aligned[1] ? SYNC_ACTIVE : SYNC_IDLE, colour[1], colour[3], colour[5]};
    end
  end

  assign bus.hpos        = hpos_q;
  assign bus.vpos        = vpos_q;
  assign bus.frame_cnt   = frame_q;
  assign bus.display_on  = display_on;
  assign bus.line_start  = (hpos_q == 10'd0);
  assign bus.frame_start = (hpos_q == 10'd0) && (vpos_q == 10'd0);
  assign bus.uo_out      = uo_q;

endmodule

// File: tb/tb_vga_sync_out.sv
// tb/tb_vga_sync_out.sv - bench for vga_sync_out on a shrunken raster with an arithmetic reference
module tb_vga_sync_out;
  localparam int HA = 12, HFP = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VB = 1;
  localparam int PIPE = 2;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  logic rst_n;
  vga_sync_out_if bus ();

  vga_sync_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_ACTIVE(1'b0), .PIPE(PIPE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         t;
  int         cmp;
  int         mism;
  logic [5:0] rgb_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s at t=%0d: observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // Expected state after t enabled clocks since reset; uo_out shows position t-1-PIPE
  task automatic check_all();
    int h, v, p, ph, pv;
    logic hs, vs, de;
    logic [5:0] c;
    logic [7:0] uo;
    h = t % HT;
    v = (t / HT) % VT;
    chk("hpos", {22'd0, bus.hpos}, h);
    chk("vpos", {22'd0, bus.vpos}, v);
    chk("frame_cnt", {24'd0, bus.frame_cnt}, (t / FT) % 256);
    chk("display_on", {31'd0, bus.display_on}, (h < HA && v < VA) ? 1 : 0);
    chk("line_start", {31'd0, bus.line_start}, (h == 0) ? 1 : 0);
    chk("frame_start", {31'd0, bus.frame_start}, (h == 0 && v == 0) ? 1 : 0);
    if (t < PIPE + 1) begin
      uo = 8'h88;
    end else begin
      p  = t - 1 - PIPE;
      ph = p % HT;
      pv = (p / HT) % VT;
      hs = (ph >= HA + HFP) && (ph < HA + HFP + HS);
      vs = (pv >= VA + VFP) && (pv < VA + VFP + VS);
      de = (ph < HA) && (pv < VA);
      c  = de ? rgb_prev : 6'd0;
      uo = {~hs, c[0], c[2], c[4], ~vs, c[1], c[3], c[5]};
    end
    chk("uo_out", {24'd0, bus.uo_out}, uo);
  endtask

  task automatic step(input logic e, input logic [5:0] rgb);
    bus.ena    = e;
    bus.rgb_in = rgb;
    @(posedge clk);
    if (e && rst_n) begin
      t++;
      rgb_prev = rgb;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int cnt;
    int ph;
    t = 0; cmp = 0; mism = 0; rgb_prev = 6'd0;
    rst_n = 1'b0;
    bus.ena = 1'b0;
    bus.rgb_in = 6'd0;

    repeat (3) step(1'b1, 6'($urandom));
    rst_n = 1'b1;
    step(1'b1, 6'($urandom));
    chk("first_hpos", {22'd0, bus.hpos}, 1);

    while (t < 30 || t % HT != 5) step(1'b1, 6'($urandom));
    repeat (50) step(1'b0, 6'($urandom));
    step(1'b1, 6'($urandom));
    chk("resume_hpos", {22'd0, bus.hpos}, 6);

    repeat (600) step($urandom_range(0, 4) != 0, 6'($urandom));

    // Renderer-like stimulus: red bits follow the column the output stage is showing
    repeat (400) begin
      ph = (t >= PIPE) ? (t - PIPE) % HT : 0;
      step(1'b1, {2'(ph), 4'($urandom)});
    end

    while (t % HT != 0) step(1'b1, 6'($urandom));
    cnt = 0;
    repeat (HT) begin
      step(1'b1, 6'($urandom));
      if (bus.uo_out[7] == 1'b0) cnt++;
    end
    chk("hsync_low_clocks", cnt, HS);

    while (t % FT != 0) step(1'b1, 6'($urandom));
    cnt = 0;
    repeat (FT) begin
      step(1'b1, 6'($urandom));
      if (bus.uo_out[3] == 1'b0) cnt++;
    end
    chk("vsync_low_clocks", cnt, VS * HT);

    while (t < 256 * FT + 3 * HT) step(1'b1, 6'($urandom));
    chk("frame_wrap", {24'd0, bus.frame_cnt}, 0);

    while (t % HT != 15) step(1'b1, 6'($urandom));
    rst_n = 1'b0;
    #1;
    t = 0;
    check_all();
    repeat (2) step(1'b1, 6'($urandom));
    rst_n = 1'b1;
    step(1'b1, 6'($urandom));
    chk("restart_hpos", {22'd0, bus.hpos}, 1);
    repeat (60) step($urandom_range(0, 3) != 0, 6'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule

// File: doc/vga_sync_out.md
Name: vga_sync_out

Overview:
- VGA timing generator and output packer for the donut design.
- Produces the raster position (hpos/vpos), the blanking flag and frame bookkeeping that drive the donut renderer.
- Takes the renderer's RGB222 pixel back, aligns it with delayed sync/blank, and drives the registered TinyVGA PMOD byte on uo_out.
- Sits directly upstream of the renderer (feeds position) and directly downstream of it (consumes colour).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, sync level while asserted (0 = negative polarity)
- PIPE, 1, renderer latency in clocks from hpos/vpos to rgb_in (0..4)

Ports:
- clk  input  1  pixel clock (25.175 MHz nominal)
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  clock enable; low = all state holds
- rgb_in  input  6  renderer colour {R1,R0,G1,G0,B1,B0}, valid PIPE clocks after its position
- hpos  output  10  current column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- display_on  output  1  hpos<H_ACTIVE && vpos<V_ACTIVE
- line_start  output  1  high while hpos==0
- frame_start  output  1  high while hpos==0 && vpos==0
- frame_cnt  output  8  frames completed, wraps 255->0
- uo_out  output  8  PMOD byte {hsync,B0,G0,R0,vsync,B1,G1,R1}

Behaviour:
- H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525).
- Reset (async assert, sync release): hpos=0, vpos=0, frame_cnt=0.
- Reset: delay-line stages = blank with sync inactive.
- Reset: uo_out = sync bits at !SYNC_ACTIVE, colour 0 (8'h88 for defaults).
- Counters, per clk with ena=1:
  - hpos increments; at H_TOTAL-1 it wraps to 0 and vpos increments.
  - vpos at V_TOTAL-1 together with hpos wrap -> vpos=0 and frame_cnt+1 (mod 256).
- hpos, vpos, frame_cnt are registers. display_on, line_start and frame_start are combinational decodes of the counter registers (0 latency).
- Raw sync:
  - hsync_raw asserted for hpos in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync_raw asserted for vpos in [490,491], over whole lines.
- Alignment:
  - {hsync_raw, vsync_raw, display_on} pass through a PIPE-stage shift register clocked with ena.
  - PIPE=0 means no stages.
- Output register, one clock after alignment:
  - colour = rgb_in when delayed display_on=1, else 0.
  - sync bits = SYNC_ACTIVE when delayed raw sync asserted, else !SYNC_ACTIVE.
  - Total latency from counter state to uo_out = PIPE+1 clocks.
- ena=0: counters, delay line and uo_out all hold; rgb_in is ignored.
- Reset asserted mid-frame: all outputs take reset values immediately, asynchronously. After release, counting restarts at (0,0) on the first enabled clock edge; no partial-frame pulse occurs.
- frame_cnt wrap: 255 -> 0 at end of frame, with no side effect on other outputs.
- Widths: counters are 10-bit unsigned. Every compare is against constant parameters, and no value exceeds 1023.

Test Plan:
- Reset then 1 enabled clock: hpos=0 → 1, vpos=0, uo_out=8'h88 while rst_n low, line_start=1 and frame_start=1 at (0,0).
- Run 800 clocks with rgb_in=6'h3F: hsync bit (uo_out[7]) low for exactly 96 clocks. The first low uo_out sample corresponds to hpos=656+PIPE+1. display_on is high for hpos 0..639.
- Run a full frame (420000 clocks): vsync (uo_out[3]) low for exactly 1600 clocks, on lines 490–491. frame_cnt goes 0→1 at the clock after (799,524). vpos is never ≥525.
- Drive rgb_in = function of delayed hpos (R1R0=hpos[1:0]) with PIPE=2: uo_out colour bits match {B0,G0,R0,B1,G1,R1} packing. Colour is 0 throughout hpos 640..799 and vpos ≥480.
- Hold ena=0 for 50 clocks at hpos=300: hpos, vpos, frame_cnt and uo_out unchanged. Counting resumes at 301 on the first clock after ena=1.
- Preload 255 frames, cross the frame end: frame_cnt=0. Then assert rst_n=0 at hpos=700: outputs reset asynchronously without a clock edge. After release, counting restarts at (0,0).
